// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: ID-stage branch request, pipeline producer info and branch control outputs
interface branch_ctrl_if;
  logic        br_valid_i;
  logic [2:0]  br_op_i;
  logic [4:0]  rs_i;
  logic [4:0]  rt_i;
  logic [31:0] target_i;
  logic        ex_we_i;
  logic        ex_load_i;
  logic [4:0]  ex_wa_i;
  logic        mem_we_i;
  logic        mem_load_i;
  logic [4:0]  mem_wa_i;
  logic        wb_we_i;
  logic [4:0]  wb_wa_i;
  logic        flush_i;
  logic        cmp_q_i;
  logic [2:0]  cmp_op_o;
  logic [1:0]  fwd_d1_o;
  logic [1:0]  fwd_d2_o;
  logic        stall_o;
  logic        redirect_o;
  logic        flush_o;
  logic [31:0] target_o;
  logic        timeout_o;
  logic        bad_op_o;
  modport master (
    output br_valid_i, br_op_i, rs_i, rt_i, target_i, ex_we_i, ex_load_i, ex_wa_i,
           mem_we_i, mem_load_i, mem_wa_i, wb_we_i, wb_wa_i, flush_i, cmp_q_i,
    input  cmp_op_o, fwd_d1_o, fwd_d2_o, stall_o, redirect_o, flush_o, target_o,
           timeout_o, bad_op_o
  );
  modport slave (
    input  br_valid_i, br_op_i, rs_i, rt_i, target_i, ex_we_i, ex_load_i, ex_wa_i,
           mem_we_i, mem_load_i, mem_wa_i, wb_we_i, wb_wa_i, flush_i, cmp_q_i,
    output cmp_op_o, fwd_d1_o, fwd_d2_o, stall_o, redirect_o, flush_o, target_o,
           timeout_o, bad_op_o
  );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch hazard/stall sequencer with registered redirect/flush pulse.
// Optional BRANCH_STATS_EN adds resolved/taken/stall-cycle counters.
module branch_ctrl #(
  parameter int MAX_STALL = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  branch_ctrl_if.slave b
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_br_o,
  output logic [31:0] stat_taken_o,
  output logic [31:0] stat_stall_o
`endif
);
  localparam int CW = $clog2(MAX_STALL + 2);
  localparam logic [CW-1:0] SAT = CW'(MAX_STALL + 1);
  typedef enum logic {IDLE, STALL} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          redirect_q, redirect_d;
  logic [31:0]   target_q, target_d;
  logic          timeout_q, timeout_d;
  logic          bad_q, bad_d;
  logic          op_bad, use_rt, v, hz, resolve, take;
  logic [4:0]    src [2];
  logic [1:0]    hzv;
  logic [1:0]    fwd [2];
  assign src[0] = b.rs_i;
  assign src[1] = b.rt_i;
  assign op_bad = b.br_op_i[2:1] == 2'b11;
  assign use_rt = b.br_op_i[2:1] == 2'b00;
  // the slot in ID during a redirect pulse is being flushed, so it is not a branch
  assign v = b.br_valid_i & ~redirect_q & ~b.flush_i;
  for (genvar i = 0; i < 2; i++) begin : g_src
    logic used, mem_m, wb_m;
    assign used  = b.br_valid_i && src[i] != 5'd0 && (i == 0 || use_rt);
    assign mem_m = (b.mem_we_i | b.mem_load_i) && b.mem_wa_i == src[i];
    assign wb_m  = b.wb_we_i && b.wb_wa_i == src[i];
    assign hzv[i] = used && ((b.ex_we_i && b.ex_wa_i == src[i]) || (b.mem_load_i && b.mem_wa_i == src[i]));
    assign fwd[i] = !used ? 2'b00 : mem_m ? (b.mem_load_i ? 2'b00 : 2'b01) : wb_m ? 2'b10 : 2'b00;
  end
  assign hz      = v & ~op_bad & |hzv;
  assign resolve = v & ~hz;
  assign take    = resolve & ~op_bad & b.cmp_q_i;
  always_comb begin
    state_d    = hz ? STALL : IDLE;
    cnt_d      = !hz ? '0 : state_q == IDLE ? CW'(1) : cnt_q == SAT ? cnt_q : cnt_q + CW'(1);
    timeout_d  = timeout_q | (cnt_d > CW'(MAX_STALL));
    bad_d      = bad_q | (v & op_bad);
    redirect_d = take;
    target_d   = take ? b.target_i : target_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
      timeout_q  <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
      timeout_q  <= timeout_d;
      bad_q      <= bad_d;
    end
  end
  assign b.cmp_op_o   = b.br_valid_i ? b.br_op_i : 3'b000;
  assign b.fwd_d1_o   = fwd[0];
  assign b.fwd_d2_o   = fwd[1];
  assign b.stall_o    = hz;
  assign b.redirect_o = redirect_q;
  assign b.flush_o    = redirect_q;
  assign b.target_o   = target_q;
  assign b.timeout_o  = timeout_q;
  assign b.bad_op_o   = bad_q;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_q, taken_q, stl_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q    <= '0;
      taken_q <= '0;
      stl_q   <= '0;
    end else begin
      br_q    <= br_q + {31'd0, resolve};
      taken_q <= taken_q + {31'd0, take};
      stl_q   <= stl_q + {31'd0, hz};
    end
  end
  assign stat_br_o    = br_q;
  assign stat_taken_o = taken_q;
  assign stat_stall_o = stl_q;
`endif
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed self-checking bench for branch_ctrl
module tb_branch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cmp = 0;
  int   mis = 0;
  branch_ctrl_if bi();
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br, stat_taken, stat_stall;
  branch_ctrl #(.MAX_STALL(3)) dut (.clk(clk), .rst_n(rst_n), .b(bi.slave),
    .stat_br_o(stat_br), .stat_taken_o(stat_taken), .stat_stall_o(stat_stall));
`else
  branch_ctrl #(.MAX_STALL(3)) dut (.clk(clk), .rst_n(rst_n), .b(bi.slave));
`endif
  always #5 clk = ~clk;

  task automatic clr;
    bi.br_valid_i = 0; bi.br_op_i = 0; bi.rs_i = 0; bi.rt_i = 0; bi.target_i = 0;
    bi.ex_we_i = 0; bi.ex_load_i = 0; bi.ex_wa_i = 0;
    bi.mem_we_i = 0; bi.mem_load_i = 0; bi.mem_wa_i = 0;
    bi.wb_we_i = 0; bi.wb_wa_i = 0; bi.flush_i = 0; bi.cmp_q_i = 0;
  endtask

  task automatic br(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                    input logic [31:0] tgt, input logic c);
    bi.br_valid_i = 1; bi.br_op_i = op; bi.rs_i = rs; bi.rt_i = rt; bi.target_i = tgt; bi.cmp_q_i = c;
  endtask

  task automatic nx;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 0; clr;
    repeat (2) nx;
    bi.ex_we_i = 1; bi.ex_wa_i = 5'd3; bi.rs_i = 5'd3;
    #1;
    cmp++; if ({bi.stall_o, bi.redirect_o, bi.flush_o, bi.timeout_o, bi.bad_op_o} !== 5'b0) begin mis++; $display("FAIL reset_flags got %b exp 00000", {bi.stall_o, bi.redirect_o, bi.flush_o, bi.timeout_o, bi.bad_op_o}); end
    cmp++; if (bi.target_o !== 32'd0) begin mis++; $display("FAIL reset_target got %h exp 0", bi.target_o); end
    cmp++; if ({bi.cmp_op_o, bi.fwd_d1_o, bi.fwd_d2_o} !== 7'b0) begin mis++; $display("FAIL reset_op_fwd got %b exp 0", {bi.cmp_op_o, bi.fwd_d1_o, bi.fwd_d2_o}); end
    nx; rst_n = 1; clr;
  endtask

  task automatic test_no_hazard;
    nx; clr; br(3'b000, 5'd3, 5'd3, 32'hA000_0010, 1'b1); #1;
    cmp++; if (bi.stall_o !== 1'b0) begin mis++; $display("FAIL nohz_stall got %b exp 0", bi.stall_o); end
    cmp++; if (bi.cmp_op_o !== 3'b000 || bi.fwd_d1_o !== 2'b00) begin mis++; $display("FAIL nohz_op_fwd got %b/%b exp 000/00", bi.cmp_op_o, bi.fwd_d1_o); end
    nx; clr; #1;
    cmp++; if (bi.redirect_o !== 1'b1 || bi.flush_o !== 1'b1) begin mis++; $display("FAIL nohz_pulse got %b%b exp 11", bi.redirect_o, bi.flush_o); end
    cmp++; if (bi.target_o !== 32'hA000_0010) begin mis++; $display("FAIL nohz_target got %h exp a0000010", bi.target_o); end
    nx; #1;
    cmp++; if (bi.redirect_o !== 1'b0 || bi.flush_o !== 1'b0) begin mis++; $display("FAIL nohz_pulse_end got %b%b exp 00", bi.redirect_o, bi.flush_o); end
  endtask

  task automatic test_ex_alu;
    nx; clr; br(3'b001, 5'd5, 5'd6, 32'hB000_0020, 1'b1); bi.ex_we_i = 1; bi.ex_wa_i = 5'd5; #1;
    cmp++; if (bi.stall_o !== 1'b1 || bi.cmp_op_o !== 3'b001) begin mis++; $display("FAIL alu_stall got %b/%b exp 1/001", bi.stall_o, bi.cmp_op_o); end
    nx; bi.ex_we_i = 0; bi.mem_we_i = 1; bi.mem_wa_i = 5'd5; #1;
    cmp++; if (bi.stall_o !== 1'b0 || bi.fwd_d1_o !== 2'b01 || bi.redirect_o !== 1'b0) begin mis++; $display("FAIL alu_fwd got %b/%b/%b exp 0/01/0", bi.stall_o, bi.fwd_d1_o, bi.redirect_o); end
    nx; clr; #1;
    cmp++; if (bi.redirect_o !== 1'b1 || bi.target_o !== 32'hB000_0020) begin mis++; $display("FAIL alu_pulse got %b/%h exp 1/b0000020", bi.redirect_o, bi.target_o); end
  endtask

  task automatic test_ex_load;
    nx; clr; br(3'b011, 5'd7, 5'd0, 32'hC000_0030, 1'b1); bi.ex_we_i = 1; bi.ex_load_i = 1; bi.ex_wa_i = 5'd7; #1;
    cmp++; if (bi.stall_o !== 1'b1) begin mis++; $display("FAIL load_stall1 got %b exp 1", bi.stall_o); end
    nx; bi.ex_we_i = 0; bi.ex_load_i = 0; bi.mem_we_i = 1; bi.mem_load_i = 1; bi.mem_wa_i = 5'd7; #1;
    cmp++; if (bi.stall_o !== 1'b1) begin mis++; $display("FAIL load_stall2 got %b exp 1", bi.stall_o); end
    nx; bi.mem_we_i = 0; bi.mem_load_i = 0; bi.wb_we_i = 1; bi.wb_wa_i = 5'd7; #1;
    cmp++; if (bi.stall_o !== 1'b0 || bi.fwd_d1_o !== 2'b10 || bi.redirect_o !== 1'b0) begin mis++; $display("FAIL load_resolve got %b/%b/%b exp 0/10/0", bi.stall_o, bi.fwd_d1_o, bi.redirect_o); end
    nx; clr; #1;
    cmp++; if (bi.redirect_o !== 1'b1 || bi.target_o !== 32'hC000_0030) begin mis++; $display("FAIL load_pulse got %b/%h exp 1/c0000030", bi.redirect_o, bi.target_o); end
    nx; clr; br(3'b011, 5'd1, 5'd7, 32'hC000_0040, 1'b0); bi.ex_we_i = 1; bi.ex_wa_i = 5'd7; bi.mem_we_i = 1; bi.mem_wa_i = 5'd7; #1;
    cmp++; if (bi.stall_o !== 1'b0 || bi.fwd_d2_o !== 2'b00) begin mis++; $display("FAIL bgtz_rt_unused got %b/%b exp 0/00", bi.stall_o, bi.fwd_d2_o); end
    nx; clr; #1;
    cmp++; if (bi.redirect_o !== 1'b0 || bi.target_o !== 32'hC000_0030) begin mis++; $display("FAIL not_taken got %b/%h exp 0/c0000030", bi.redirect_o, bi.target_o); end
  endtask

  task automatic test_fwd;
    nx; clr; br(3'b000, 5'd0, 5'd0, 32'h0, 1'b0); bi.ex_we_i = 1; bi.ex_wa_i = 5'd0; bi.wb_we_i = 1; bi.wb_wa_i = 5'd0; #1;
    cmp++; if (bi.stall_o !== 1'b0 || bi.fwd_d1_o !== 2'b00 || bi.fwd_d2_o !== 2'b00) begin mis++; $display("FAIL r0 got %b/%b/%b exp 0/00/00", bi.stall_o, bi.fwd_d1_o, bi.fwd_d2_o); end
    nx; clr; br(3'b001, 5'd4, 5'd9, 32'h0, 1'b0); bi.mem_we_i = 1; bi.mem_wa_i = 5'd4; bi.wb_we_i = 1; bi.wb_wa_i = 5'd4; #1;
    cmp++; if (bi.fwd_d1_o !== 2'b01 || bi.fwd_d2_o !== 2'b00 || bi.stall_o !== 1'b0) begin mis++; $display("FAIL mem_over_wb got %b/%b/%b exp 01/00/0", bi.fwd_d1_o, bi.fwd_d2_o, bi.stall_o); end
    bi.wb_wa_i = 5'd9; #1;
    cmp++; if (bi.fwd_d2_o !== 2'b10) begin mis++; $display("FAIL wb_rt got %b exp 10", bi.fwd_d2_o); end
    bi.br_valid_i = 0; #1;
    cmp++; if (bi.fwd_d1_o !== 2'b00 || bi.fwd_d2_o !== 2'b00 || bi.cmp_op_o !== 3'b000) begin mis++; $display("FAIL idle_fwd got %b/%b/%b exp 00/00/000", bi.fwd_d1_o, bi.fwd_d2_o, bi.cmp_op_o); end
  endtask

  task automatic test_timeout;
    nx; clr; br(3'b010, 5'd8, 5'd0, 32'hD000_0050, 1'b0); bi.ex_we_i = 1; bi.ex_wa_i = 5'd8;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nx;
      #1;
      cmp++; if (bi.stall_o !== 1'b1) begin mis++; $display("FAIL to_stall%0d got %b exp 1", i, bi.stall_o); end
    end
    cmp++; if (bi.timeout_o !== 1'b0) begin mis++; $display("FAIL to_early got %b exp 0", bi.timeout_o); end
    nx; bi.ex_we_i = 0; #1;
    cmp++; if (bi.timeout_o !== 1'b1 || bi.stall_o !== 1'b0) begin mis++; $display("FAIL to_set got %b/%b exp 1/0", bi.timeout_o, bi.stall_o); end
    nx; clr; #1;
    cmp++; if (bi.timeout_o !== 1'b1 || bi.redirect_o !== 1'b0) begin mis++; $display("FAIL to_sticky got %b/%b exp 1/0", bi.timeout_o, bi.redirect_o); end
  endtask

  task automatic test_flush;
    nx; clr; br(3'b000, 5'd10, 5'd11, 32'hE000_0060, 1'b1); bi.ex_we_i = 1; bi.ex_wa_i = 5'd11; #1;
    cmp++; if (bi.stall_o !== 1'b1) begin mis++; $display("FAIL fl_stall got %b exp 1", bi.stall_o); end
    nx; bi.flush_i = 1; #1;
    cmp++; if (bi.stall_o !== 1'b0) begin mis++; $display("FAIL fl_override got %b exp 0", bi.stall_o); end
    nx; bi.ex_we_i = 0; #1;
    nx; clr; #1;
    cmp++; if (bi.redirect_o !== 1'b0 || bi.flush_o !== 1'b0 || bi.timeout_o !== 1'b1) begin mis++; $display("FAIL fl_nopulse got %b%b/%b exp 00/1", bi.redirect_o, bi.flush_o, bi.timeout_o); end
  endtask

  task automatic test_bad_op;
    nx; clr; br(3'b111, 5'd12, 5'd0, 32'hF000_0070, 1'b1); bi.ex_we_i = 1; bi.ex_wa_i = 5'd12; #1;
    cmp++; if (bi.stall_o !== 1'b0 || bi.bad_op_o !== 1'b0) begin mis++; $display("FAIL bad_nostall got %b/%b exp 0/0", bi.stall_o, bi.bad_op_o); end
    nx; clr; #1;
    cmp++; if (bi.bad_op_o !== 1'b1 || bi.redirect_o !== 1'b0) begin mis++; $display("FAIL bad_set got %b/%b exp 1/0", bi.bad_op_o, bi.redirect_o); end
  endtask

  task automatic test_back_to_back;
    nx; clr; br(3'b101, 5'd2, 5'd0, 32'h1234_5678, 1'b1); #1;
    nx; br(3'b101, 5'd2, 5'd0, 32'h8765_4321, 1'b1); #1;
    cmp++; if (bi.redirect_o !== 1'b1 || bi.target_o !== 32'h1234_5678) begin mis++; $display("FAIL b2b_first got %b/%h exp 1/12345678", bi.redirect_o, bi.target_o); end
    nx; clr; #1;
    cmp++; if (bi.redirect_o !== 1'b0 || bi.target_o !== 32'h1234_5678) begin mis++; $display("FAIL b2b_ignored got %b/%h exp 0/12345678", bi.redirect_o, bi.target_o); end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats;
    nx; clr; rst_n = 0; #1;
    cmp++; if ({stat_br, stat_taken, stat_stall} !== 96'd0) begin mis++; $display("FAIL st_reset got %0d/%0d/%0d exp 0/0/0", stat_br, stat_taken, stat_stall); end
    nx; rst_n = 1;
    nx; br(3'b000, 5'd1, 5'd1, 32'h10, 1'b1);
    nx; clr;
    nx; br(3'b001, 5'd5, 5'd6, 32'h20, 1'b1); bi.ex_we_i = 1; bi.ex_wa_i = 5'd5;
    nx; bi.ex_we_i = 0;
    nx; clr;
    nx; br(3'b000, 5'd1, 5'd2, 32'h30, 1'b0);
    nx; clr; #1;
    cmp++; if (stat_br !== 32'd3 || stat_taken !== 32'd2 || stat_stall !== 32'd1) begin mis++; $display("FAIL st_counts got %0d/%0d/%0d exp 3/2/1", stat_br, stat_taken, stat_stall); end
  endtask
`endif

  task automatic test_async_reset;
    nx; clr; br(3'b000, 5'd3, 5'd3, 32'h5555_AAAA, 1'b1);
    nx; br(3'b111, 5'd0, 5'd0, 32'h0, 1'b0); #1;
    cmp++; if (bi.redirect_o !== 1'b1) begin mis++; $display("FAIL ar_pre got %b exp 1", bi.redirect_o); end
    nx; clr; #2; rst_n = 0; #1;
    cmp++; if ({bi.redirect_o, bi.flush_o, bi.bad_op_o, bi.timeout_o, bi.stall_o} !== 5'b0 || bi.target_o !== 32'd0) begin mis++; $display("FAIL ar_clear got %b/%h exp 00000/0", {bi.redirect_o, bi.flush_o, bi.bad_op_o, bi.timeout_o, bi.stall_o}, bi.target_o); end
    nx; rst_n = 1;
  endtask

  initial begin
    clr;
    test_reset;
    test_no_hazard;
    test_ex_alu;
    test_ex_load;
    test_fwd;
    test_timeout;
    test_flush;
    test_bad_op;
    test_back_to_back;
`ifdef BRANCH_STATS_EN
    test_stats;
    bi.br_valid_i = 0;
    nx; bi.ex_we_i = 1; bi.ex_wa_i = 5'd4; br(3'b000, 5'd4, 5'd0, 32'h0, 1'b0);
    repeat (5) nx;
    clr; bi.br_valid_i = 0;
`endif
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
